// File: rtl/uart_cmd_dispatch_pkg.sv
// Shared constants, state encodings and helpers for the UART command dispatcher.
// P_QUERY is only reachable when UART_CMD_QUERY_EN is defined.
package uart_cmd_dispatch_pkg;

  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_Q = 8'h51;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_N = 8'h4E;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_CHAN  = 3'd1,
    P_RATE  = 3'd2,
    P_EXEC  = 3'd3,
    P_QUERY = 3'd4
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_WAITHI = 2'd1,
    T_WAITLO = 2'd2
  } tx_state_t;

  // True when b is an ASCII digit in '0' .. '0'+n-1.
  function automatic logic ascii_in_range(input logic [7:0] b, input int unsigned n);
    return (b >= ASCII_0) && (b < (ASCII_0 + 8'(n)));
  endfunction

endpackage

// File: rtl/uart_cmd_txq.sv
// Response FIFO, 8 bits wide; pointers carry an extra wrap bit to tell full from empty.
module uart_cmd_txq #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A simultaneous pop frees the slot, so a push on full is still accepted.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_cmd_dispatch.sv
// UART command dispatcher: parses 'S',<chan>,<rate> frames and queues 'R'/'N'/'E' replies.
// Define UART_CMD_QUERY_EN to add the 'Q',<chan> rate readback opcode.
module uart_cmd_dispatch
  import uart_cmd_dispatch_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned RATE_W         = 2,
  parameter int unsigned TXQ_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     button,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [N_CH-1:0]          new_pattern,
  output logic [N_CH*RATE_W-1:0]   pulse_rate,
  output logic                     txq_overflow,
  output logic                     frame_err
);

  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned N_RATE = 1 << RATE_W;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  parse_state_t      p_state;
  parse_state_t      chan_next;
  tx_state_t         t_state;
  logic [CH_W-1:0]   chan_q;
  logic [RATE_W-1:0] rate_q;
  logic [TO_W-1:0]   to_cnt;
  logic              rx_ready_prev;
  logic              byte_acc;
  logic              opc_ok;
  logic              chan_ok;
  logic              rate_ok;
  logic              counting;
  logic              to_hit;
  logic              p_push;
  logic [7:0]        p_din;
  logic              p_nack;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_prev;
  logic              btn_pend;
  logic              btn_evt;
  logic              q_push;
  logic [7:0]        q_din;
  logic              q_pop;
  logic [7:0]        q_dout;
  logic              q_empty;
  logic              q_full;
  logic              hi_wait;

  // NUL bytes are line noise from the host side and never reach the parser.
  assign byte_acc = rx_ready && !rx_ready_prev && (rx_data != 8'h00);
  assign chan_ok  = ascii_in_range(rx_data, N_CH);
  assign rate_ok  = ascii_in_range(rx_data, N_RATE);
  assign counting = (p_state == P_CHAN) || (p_state == P_RATE);
  assign to_hit   = counting && !byte_acc && (to_cnt == TO_LAST);

`ifdef UART_CMD_QUERY_EN
  logic is_query;

  assign opc_ok    = (rx_data == ASCII_S) || (rx_data == ASCII_Q);
  assign chan_next = is_query ? P_QUERY : P_RATE;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          is_query <= 1'b0;
    else if (p_state == P_IDLE && byte_acc)  is_query <= (rx_data == ASCII_Q);
  end
`else
  assign opc_ok    = (rx_data == ASCII_S);
  assign chan_next = P_RATE;
`endif

  // Parser response decode: at most one byte pushed per cycle.
  always_comb begin
    p_push = 1'b0;
    p_din  = ASCII_N;
    p_nack = 1'b0;
    case (p_state)
      P_IDLE: p_nack = byte_acc && !opc_ok;
      P_CHAN: p_nack = byte_acc ? !chan_ok : to_hit;
      P_RATE: p_nack = byte_acc ? !rate_ok : to_hit;
      P_EXEC: begin
        p_push = 1'b1;
        p_din  = ASCII_R;
      end
`ifdef UART_CMD_QUERY_EN
      P_QUERY: begin
        p_push = 1'b1;
        p_din  = ASCII_0 + 8'(pulse_rate[32'(chan_q)*RATE_W +: RATE_W]);
      end
`endif
      default: ;
    endcase
    if (p_nack) begin
      p_push = 1'b1;
      p_din  = ASCII_N;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      p_state     <= P_IDLE;
      chan_q      <= '0;
      rate_q      <= '0;
      pulse_rate  <= '0;
      new_pattern <= '0;
      frame_err   <= 1'b0;
    end else begin
      new_pattern <= '0;
      frame_err   <= p_nack;
      case (p_state)
        P_IDLE: if (byte_acc && opc_ok) p_state <= P_CHAN;
        P_CHAN: begin
          if (byte_acc) begin
            if (chan_ok) begin
              chan_q  <= CH_W'(rx_data - ASCII_0);
              p_state <= chan_next;
            end else begin
              p_state <= P_IDLE;
            end
          end else if (to_hit) begin
            p_state <= P_IDLE;
          end
        end
        P_RATE: begin
          if (byte_acc) begin
            if (rate_ok) begin
              rate_q  <= RATE_W'(rx_data - ASCII_0);
              p_state <= P_EXEC;
            end else begin
              p_state <= P_IDLE;
            end
          end else if (to_hit) begin
            p_state <= P_IDLE;
          end
        end
        P_EXEC: begin
          pulse_rate[32'(chan_q)*RATE_W +: RATE_W] <= rate_q;
          new_pattern[chan_q]                      <= 1'b1;
          p_state                                  <= P_IDLE;
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end

  // Inter-byte timeout only runs while a frame is partially received.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                 to_cnt <= '0;
    else if (byte_acc || !counting) to_cnt <= '0;
    else                            to_cnt <= to_cnt + TO_ONE;
  end

  // Button sync, falling-edge detect, and rx edge history.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_s1        <= 1'b1;
      btn_s2        <= 1'b1;
      btn_prev      <= 1'b1;
      btn_pend      <= 1'b0;
      rx_ready_prev <= 1'b0;
      txq_overflow  <= 1'b0;
    end else begin
      btn_s1        <= button;
      btn_s2        <= btn_s1;
      btn_prev      <= btn_s2;
      btn_pend      <= p_push && btn_evt;
      rx_ready_prev <= rx_ready;
      if (q_push && q_full && !q_pop) txq_overflow <= 1'b1;
    end
  end

  // Parser wins the single push slot; a losing button event waits in btn_pend.
  assign btn_evt = (btn_prev && !btn_s2) || btn_pend;
  assign q_push  = p_push || btn_evt;
  assign q_din   = p_push ? p_din : ASCII_E;
  assign q_pop   = (t_state == T_IDLE) && !q_empty && !tx_busy;

  uart_cmd_txq #(
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (q_push),
    .din       (q_din),
    .pop       (q_pop),
    .dout      (q_dout),
    .empty     (q_empty),
    .full      (q_full)
  );

  // TX engine; gives uart_tx two cycles to raise busy before moving on.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      t_state  <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      hi_wait  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (t_state)
        T_IDLE: begin
          if (q_pop) begin
            tx_data  <= q_dout;
            tx_start <= 1'b1;
            hi_wait  <= 1'b0;
            t_state  <= T_WAITHI;
          end
        end
        T_WAITHI: begin
          if (tx_busy || hi_wait) t_state <= T_WAITLO;
          else                    hi_wait <= 1'b1;
        end
        T_WAITLO: if (!tx_busy) t_state <= T_IDLE;
        default:  t_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed bench for uart_cmd_dispatch: frame vector table plus timing, button, timeout,
// overflow and mid-frame reset sequences. A small uart_tx model records sent bytes.
module tb_uart_cmd_dispatch;

  localparam int unsigned N_CH = 4;
  localparam int unsigned RATE_W = 2;
  localparam int unsigned TO_CYC = 40;

  localparam logic [7:0] C_S = 8'h53;
  localparam logic [7:0] C_Q = 8'h51;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_N = 8'h4E;
  localparam logic [7:0] C_E = 8'h45;
  localparam logic [7:0] C_X = 8'h58;

  logic                   clk;
  logic                   rst_n;
  logic [7:0]             rx_data;
  logic                   rx_ready;
  logic                   button;
  logic                   tx_busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic [N_CH-1:0]        new_pattern;
  logic [N_CH*RATE_W-1:0] pulse_rate;
  logic                   txq_overflow;
  logic                   frame_err;

  uart_cmd_dispatch #(
    .N_CH           (N_CH),
    .RATE_W         (RATE_W),
    .TXQ_DEPTH      (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .button       (button),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .new_pattern  (new_pattern),
    .pulse_rate   (pulse_rate),
    .txq_overflow (txq_overflow),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] tx_log[$];
  int         np_cnt = 0;
  logic [3:0] np_last = '0;
  int         err_cnt = 0;
  logic       tx_hold = 1'b0;
  int         busy_cnt;

  typedef struct {
    logic [3:0][7:0] b;
    int              n;
    logic [7:0]      tx;
    logic [7:0]      rate;
    logic [3:0]      np;
    int              err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int n, input logic [7:0] tx,
                              input logic [7:0] rate, input logic [3:0] np, input int err);
    vec_t v;
    v.b    = {b3, b2, b1, b0};
    v.n    = n;
    v.tx   = tx;
    v.rate = rate;
    v.np   = np;
    v.err  = err;
    return v;
  endfunction

  // uart_tx model: logs each started byte and stays busy for 4 cycles.
  initial begin
    busy_cnt = 0;
    tx_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_log.push_back(tx_data);
        busy_cnt = 4;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      tx_busy = tx_hold || (busy_cnt > 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (new_pattern != '0) begin
        np_cnt++;
        np_last = new_pattern;
      end
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_tx(input int target, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (tx_log.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  function automatic logic [7:0] log_at(input int idx);
    return (idx < tx_log.size()) ? tx_log[idx] : 8'h00;
  endfunction

  vec_t vecs[11];
  int   n0, e0, p0;
  logic ok;

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    button   = 1'b1;

    vecs[0]  = mk(C_S, "2", "3", 8'h00, 3, C_R, 8'h30, 4'b0100, 0);
    vecs[1]  = mk(C_S, "7", 8'h00, 8'h00, 2, C_N, 8'h30, 4'b0000, 1);
    vecs[2]  = mk(C_S, "0", "1", 8'h00, 3, C_R, 8'h31, 4'b0001, 0);
    vecs[3]  = mk(C_S, "3", "2", 8'h00, 3, C_R, 8'hB1, 4'b1000, 0);
    vecs[4]  = mk(C_S, "1", "4", 8'h00, 3, C_N, 8'hB1, 4'b0000, 1);
    vecs[5]  = mk(C_S, "4", 8'h00, 8'h00, 2, C_N, 8'hB1, 4'b0000, 1);
    vecs[6]  = mk("A", 8'h00, 8'h00, 8'h00, 1, C_N, 8'hB1, 4'b0000, 1);
    vecs[7]  = mk(C_S, "3", "3", 8'h00, 3, C_R, 8'hF1, 4'b1000, 0);
    vecs[8]  = mk(C_S, 8'h00, "1", "2", 4, C_R, 8'hF9, 4'b0010, 0);
`ifdef UART_CMD_QUERY_EN
    vecs[9]  = mk(C_Q, "1", 8'h00, 8'h00, 2, "2", 8'hF9, 4'b0000, 0);
`else
    vecs[9]  = mk(C_Q, 8'h00, 8'h00, 8'h00, 1, C_N, 8'hF9, 4'b0000, 1);
`endif
    vecs[10] = mk(C_S, "0", "0", 8'h00, 3, C_R, 8'hF8, 4'b0001, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse_rate", 32'(pulse_rate), 32'h0);
    chk("rst_new_pattern", 32'(new_pattern), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_overflow", 32'(txq_overflow), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      n0 = tx_log.size();
      e0 = err_cnt;
      p0 = np_cnt;
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
      wait_tx(n0 + 1, ok);
      chk($sformatf("v%0d_tx_seen", i), 32'(ok), 32'h1);
      repeat (15) @(posedge clk);
      #1;
      chk($sformatf("v%0d_tx_byte", i), 32'(log_at(n0)), 32'(vecs[i].tx));
      chk($sformatf("v%0d_tx_count", i), 32'(tx_log.size() - n0), 32'h1);
      chk($sformatf("v%0d_rate", i), 32'(pulse_rate), 32'(vecs[i].rate));
      chk($sformatf("v%0d_np_cycles", i), 32'(np_cnt - p0), (vecs[i].np != 0) ? 32'h1 : 32'h0);
      if (vecs[i].np != 0) chk($sformatf("v%0d_np_value", i), 32'(np_last), 32'(vecs[i].np));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].err));
    end

    // Cycle-exact latency: rate byte in cycle t, strobe at t+2, tx_start at t+3.
    n0 = tx_log.size();
    send_byte(C_S);
    send_byte("2");
    @(posedge clk);
    #1;
    rx_data  = "1";
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("lat_np_t1", 32'(new_pattern), 32'h0);
    chk("lat_rate_t1", 32'(pulse_rate), 32'hF8);
    @(posedge clk);
    #1;
    chk("lat_np_t2", 32'(new_pattern), 32'h4);
    chk("lat_rate_t2", 32'(pulse_rate), 32'hD8);
    chk("lat_start_t2", 32'(tx_start), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_start_t3", 32'(tx_start), 32'h1);
    chk("lat_data_t3", 32'(tx_data), 32'(C_R));
    @(posedge clk);
    #1;
    chk("lat_np_t3", 32'(new_pattern), 32'h0);
    repeat (15) @(posedge clk);

    // Button falling edge lands in the P_EXEC cycle: 'R' first, then 'E'.
    n0 = tx_log.size();
    send_byte(C_S);
    send_byte("1");
    @(posedge clk);
    #1;
    button = 1'b0;
    @(posedge clk);
    #1;
    rx_data  = "1";
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    wait_tx(n0 + 2, ok);
    chk("btn_tx_seen", 32'(ok), 32'h1);
    repeat (20) @(posedge clk);
    button = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("btn_count", 32'(tx_log.size() - n0), 32'h2);
    chk("btn_first", 32'(log_at(n0)), 32'(C_R));
    chk("btn_second", 32'(log_at(n0 + 1)), 32'(C_E));
    chk("btn_rate", 32'(pulse_rate), 32'hD4);

    // Partial frame timeout, then a normal frame.
    n0 = tx_log.size();
    e0 = err_cnt;
    send_byte(C_S);
    repeat (20) @(posedge clk);
    #1;
    chk("to_not_early", 32'(tx_log.size() - n0), 32'h0);
    wait_tx(n0 + 1, ok);
    chk("to_tx_seen", 32'(ok), 32'h1);
    repeat (15) @(posedge clk);
    #1;
    chk("to_byte", 32'(log_at(n0)), 32'(C_N));
    chk("to_err", 32'(err_cnt - e0), 32'h1);
    n0 = tx_log.size();
    send_byte(C_S);
    send_byte("0");
    send_byte("1");
    wait_tx(n0 + 1, ok);
    repeat (15) @(posedge clk);
    #1;
    chk("to_next_byte", 32'(log_at(n0)), 32'(C_R));
    chk("to_next_rate", 32'(pulse_rate), 32'hD5);

    // Six nacks while uart_tx is stuck busy: four queued, two dropped.
    tx_hold = 1'b1;
    repeat (3) @(posedge clk);
    n0 = tx_log.size();
    e0 = err_cnt;
    for (int k = 0; k < 6; k++) send_byte(C_X);
    #1;
    chk("ovf_flag", 32'(txq_overflow), 32'h1);
    chk("ovf_err", 32'(err_cnt - e0), 32'h6);
    chk("ovf_held", 32'(tx_log.size() - n0), 32'h0);
    tx_hold = 1'b0;
    wait_tx(n0 + 4, ok);
    chk("ovf_tx_seen", 32'(ok), 32'h1);
    repeat (60) @(posedge clk);
    #1;
    chk("ovf_count", 32'(tx_log.size() - n0), 32'h4);
    for (int k = 0; k < 4; k++) chk($sformatf("ovf_byte%0d", k), 32'(log_at(n0 + k)), 32'(C_N));
    chk("ovf_sticky", 32'(txq_overflow), 32'h1);

    // Reset mid-frame with a queued reply: frame and FIFO are discarded.
    tx_hold = 1'b1;
    repeat (3) @(posedge clk);
    n0 = tx_log.size();
    p0 = np_cnt;
    send_byte(C_X);
    send_byte(C_S);
    send_byte("2");
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_rate", 32'(pulse_rate), 32'h0);
    chk("mrst_overflow", 32'(txq_overflow), 32'h0);
    rst_n   = 1'b1;
    tx_hold = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mrst_flushed", 32'(tx_log.size() - n0), 32'h0);
    chk("mrst_no_strobe", 32'(np_cnt - p0), 32'h0);
    send_byte("3");
    wait_tx(n0 + 1, ok);
    repeat (15) @(posedge clk);
    #1;
    chk("mrst_next_byte", 32'(log_at(n0)), 32'(C_N));
    chk("mrst_rate_after", 32'(pulse_rate), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
